// File: rtl/conv_in_feature_map_line_writer_pkg.sv
// Shared constants and helpers for the convolution input feature-map line
// buffer: the write-side producer, the buffer and the read-side controller.
package conv_in_feature_map_line_writer_pkg;

  // Number of rotating row slots in the line buffer.
  localparam int unsigned slot_count = 3;
  // Buffer word width in bits.
  localparam int unsigned word_width = 64;

  // Default build values, and the figures derived from them.
  localparam int unsigned default_feature_data_width = 16;
  localparam int unsigned default_max_feature_map_w  = 512;

  typedef logic [1:0] slot_t;

  // Number of bits needed to represent v. Returns at least 1.
  function automatic int unsigned clogb2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((v >> i) != 0) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  // Feature points packed into one buffer word.
  function automatic int unsigned points_per_word(input int unsigned fw);
    return word_width / fw;
  endfunction

  // Row depth in buffer words.
  function automatic int unsigned row_depth(input int unsigned max_w, input int unsigned fw);
    return (max_w * fw) / word_width;
  endfunction

  // Word address width within one row.
  function automatic int unsigned addr_width(input int unsigned max_w, input int unsigned fw);
    return clogb2(row_depth(max_w, fw) - 1);
  endfunction

  localparam int unsigned default_points_per_word =
    points_per_word(default_feature_data_width);
  localparam int unsigned default_row_depth =
    row_depth(default_max_feature_map_w, default_feature_data_width);
  localparam int unsigned default_addr_width =
    addr_width(default_max_feature_map_w, default_feature_data_width);

  // Slot index after s, wrapping 2 -> 0.
  function automatic slot_t next_slot(input slot_t s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  // One-hot write enable for slot s.
  function automatic logic [2:0] slot_onehot(input slot_t s);
    return 3'b001 << s;
  endfunction

endpackage

// File: rtl/conv_in_feature_map_line_writer_if.sv
// AXIS feature-point stream into the line writer.
// Handshake: a beat transfers on a rising clk edge where valid and ready are
// both high. The master holds data/user/last stable while valid is high and
// ready is low; ready may change at any time and never depends on valid.
interface conv_in_feature_map_line_writer_if #(
  parameter int unsigned user_width = 4
);
  logic [63:0]           data;
  logic [user_width-1:0] user;
  logic                  last;
  logic                  valid;
  logic                  ready;

  modport master (output data, output user, output last, output valid, input ready);
  modport slave  (input data, input user, input last, input valid, output ready);
endinterface

// File: rtl/conv_in_feature_map_line_writer_slot_tracker.sv
// Row-slot occupancy tracker: mod-3 write slot, oldest complete slot and
// the count of complete rows held in the line buffer.
module conv_line_slot_tracker
  import conv_in_feature_map_line_writer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       complete,
  input  logic       row_release,
  output slot_t      wr_slot,
  output slot_t      oldest_slot,
  output logic [1:0] rows_valid
);

  // A release only counts when there is a complete row to release.
  logic release_eff;
  assign release_eff = row_release && (rows_valid != 2'd0);

  // Slot pointers and occupancy; clear wins over complete and release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_slot     <= 2'd0;
      oldest_slot <= 2'd0;
      rows_valid  <= 2'd0;
    end else if (clear) begin
      wr_slot     <= 2'd0;
      oldest_slot <= 2'd0;
      rows_valid  <= 2'd0;
    end else begin
      if (complete) wr_slot <= next_slot(wr_slot);
      if (release_eff) oldest_slot <= next_slot(oldest_slot);
      // complete is only possible below 3 rows, so the count cannot wrap.
      if (complete && !release_eff) rows_valid <= rows_valid + 2'd1;
      else if (release_eff && !complete) rows_valid <= rows_valid - 2'd1;
    end
  end

endmodule

// File: rtl/conv_in_feature_map_line_writer.sv
// Write-side producer for the 3-row input feature-map line buffer. Each AXIS
// packet is one feature-map row; beats are written through a registered
// write port into the current row slot.
module conv_in_feature_map_line_writer
  import conv_in_feature_map_line_writer_pkg::*;
#(
  parameter int unsigned feature_data_width = 16,
  parameter int unsigned max_feature_map_w  = 512,
  // Kept for parity with the behavioural model; registers update on the edge.
  parameter int unsigned simulation_delay   = 1
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  conv_in_feature_map_line_writer_if.slave             s_axis,
  input  logic                                         fmap_clr,
  input  logic                                         row_release,
  output logic [2:0]                                   buffer_wen,
  output logic [15:0]                                  buffer_waddr,
  output logic [63:0]                                  buffer_din,
  output logic [points_per_word(feature_data_width)-1:0] buffer_din_last,
  output logic [1:0]                                   rows_valid,
  output logic [1:0]                                   oldest_slot,
  output logic                                         row_done,
  output logic                                         wr_overflow
);

  localparam int unsigned depth = row_depth(max_feature_map_w, feature_data_width);
  localparam int unsigned aw    = addr_width(max_feature_map_w, feature_data_width);
  // The beat counter must reach depth itself to mark the saturated state.
  localparam int unsigned cnt_w = clogb2(depth);
  localparam logic [cnt_w-1:0] depth_c = cnt_w'(depth);

  logic [cnt_w-1:0] beat_cnt;
  slot_t            wr_slot;
  logic             hs;
  logic             complete;
  logic             in_range;

  // Ready is held low in reset, when all slots are full, and during a flush.
  assign s_axis.ready = rst_n && (rows_valid != 2'd3) && !fmap_clr;
  assign hs           = s_axis.valid && s_axis.ready;
  assign complete     = hs && s_axis.last;
  assign in_range     = (beat_cnt < depth_c);

  conv_line_slot_tracker u_slot_tracker (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (fmap_clr),
    .complete    (complete),
    .row_release (row_release),
    .wr_slot     (wr_slot),
    .oldest_slot (oldest_slot),
    .rows_valid  (rows_valid)
  );

  // Registered write port, beat counter and overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buffer_wen      <= '0;
      buffer_waddr    <= '0;
      buffer_din      <= '0;
      buffer_din_last <= '0;
      beat_cnt        <= '0;
      row_done        <= 1'b0;
      wr_overflow     <= 1'b0;
    end else begin
      buffer_wen <= '0;
      row_done   <= 1'b0;
      if (fmap_clr) begin
        // Abandon any partial row; ready is low so no beat lands this cycle.
        beat_cnt    <= '0;
        wr_overflow <= 1'b0;
      end else if (hs) begin
        if (in_range) begin
          buffer_wen      <= slot_onehot(wr_slot);
          buffer_waddr    <= 16'(beat_cnt[aw-1:0]);
          buffer_din      <= s_axis.data;
          buffer_din_last <= s_axis.user;
        end else begin
          wr_overflow <= 1'b1;
        end
        if (s_axis.last) beat_cnt <= '0;
        else if (in_range) beat_cnt <= beat_cnt + cnt_w'(1);
        row_done <= s_axis.last;
      end
    end
  end

endmodule

// File: tb/tb_conv_in_feature_map_line_writer.sv
// Directed bench for the line writer, built with a 4-word row depth
// (fw=16, max_feature_map_w=16) so overflow is reachable.
module tb_conv_in_feature_map_line_writer;
  import conv_in_feature_map_line_writer_pkg::*;

  localparam int unsigned fw    = 16;
  localparam int unsigned max_w = 16;
  localparam int unsigned ppw   = 4;
  localparam int unsigned depth = 4;
  localparam int W = 88;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fmap_clr = 1'b0;
  logic        row_release = 1'b0;
  logic [2:0]  buffer_wen;
  logic [15:0] buffer_waddr;
  logic [63:0] buffer_din;
  logic [ppw-1:0] buffer_din_last;
  logic [1:0]  rows_valid;
  logic [1:0]  oldest_slot;
  logic        row_done;
  logic        wr_overflow;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  // {wen[3], addr[16], din[64], din_last[4], row_done[1]}
  logic [W-1:0] exp_q[$];
  logic [W-1:0] e_rec;

  conv_in_feature_map_line_writer_if #(.user_width(ppw)) s_axis_if ();

  conv_in_feature_map_line_writer #(
    .feature_data_width (fw),
    .max_feature_map_w  (max_w),
    .simulation_delay   (1)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_axis          (s_axis_if.slave),
    .fmap_clr        (fmap_clr),
    .row_release     (row_release),
    .buffer_wen      (buffer_wen),
    .buffer_waddr    (buffer_waddr),
    .buffer_din      (buffer_din),
    .buffer_din_last (buffer_din_last),
    .rows_valid      (rows_valid),
    .oldest_slot     (oldest_slot),
    .row_done        (row_done),
    .wr_overflow     (wr_overflow)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: every write seen on the port must match the oldest expected one.
  always @(negedge clk) begin
    if (row_done) done_cnt++;
    if (buffer_wen != 3'b000) begin
      if (exp_q.size() == 0) begin
        check("unexp_wen", {61'd0, buffer_wen}, 64'd0);
      end else begin
        e_rec = exp_q.pop_front();
        check("wen",      {61'd0, buffer_wen},      {61'd0, e_rec[87:85]});
        check("waddr",    {48'd0, buffer_waddr},    {48'd0, e_rec[84:69]});
        check("din",      buffer_din,               e_rec[68:5]);
        check("din_last", {60'd0, buffer_din_last}, {60'd0, e_rec[4:1]});
        check("done_aln", {63'd0, row_done},        {63'd0, e_rec[0]});
      end
    end
  end

  // Driver: present one beat, wait for ready (bounded), complete on the edge.
  task automatic send_beat(input logic [63:0] d, input logic [3:0] u, input logic l,
                           input logic push, input logic [2:0] wen_exp,
                           input logic [15:0] addr_exp, input logic rel);
    int n;
    @(negedge clk);
    s_axis_if.data  = d;
    s_axis_if.user  = u;
    s_axis_if.last  = l;
    s_axis_if.valid = 1'b1;
    row_release     = rel;
    if (push) exp_q.push_back({wen_exp, addr_exp, d, u, l});
    n = 0;
    while (!s_axis_if.ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!s_axis_if.ready) check("ready_timeout", {63'd0, s_axis_if.ready}, 64'd1);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    s_axis_if.valid = 1'b0;
    s_axis_if.last  = 1'b0;
    row_release     = 1'b0;
    fmap_clr        = 1'b0;
  endtask

  task automatic send_row(input int row, input logic [2:0] wen_exp, input int nbeats,
                          input logic rel_last);
    for (int b = 0; b < nbeats; b++) begin
      logic [63:0] d;
      logic        l;
      d = {16'hC0DE, 16'(row), 16'h0000, 16'(b)};
      l = (b == nbeats - 1);
      send_beat(d, l ? 4'b1000 : 4'b0000, l, (b < depth), wen_exp, 16'(b), l && rel_last);
    end
    idle();
  endtask

  task automatic pulse_release();
    @(negedge clk);
    row_release = 1'b1;
    @(negedge clk);
    row_release = 1'b0;
  endtask

  task automatic check_state(input string tag, input logic [1:0] rv, input logic [1:0] old);
    check({tag, "_rows_valid"}, {62'd0, rows_valid}, {62'd0, rv});
    check({tag, "_oldest"},     {62'd0, oldest_slot}, {62'd0, old});
  endtask

  initial begin
    s_axis_if.data  = 64'd0;
    s_axis_if.user  = '0;
    s_axis_if.last  = 1'b0;
    s_axis_if.valid = 1'b1;

    // Reset values, with valid high during reset.
    #12;
    check("rst_wen",      {61'd0, buffer_wen}, 64'd0);
    check("rst_waddr",    {48'd0, buffer_waddr}, 64'd0);
    check("rst_din",      buffer_din, 64'd0);
    check("rst_din_last", {60'd0, buffer_din_last}, 64'd0);
    check_state("rst", 2'd0, 2'd0);
    check("rst_row_done", {63'd0, row_done}, 64'd0);
    check("rst_overflow", {63'd0, wr_overflow}, 64'd0);
    check("rst_ready",    {63'd0, s_axis_if.ready}, 64'd0);
    @(negedge clk);
    s_axis_if.valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", {63'd0, s_axis_if.ready}, 64'd1);

    // Three rows fill all slots.
    send_row(0, 3'b001, 4, 1'b0);
    send_row(1, 3'b010, 4, 1'b0);
    send_row(2, 3'b100, 4, 1'b0);
    @(negedge clk);
    check_state("full", 2'd3, 2'd0);
    check("full_ready", {63'd0, s_axis_if.ready}, 64'd0);
    check("full_done_cnt", 64'(done_cnt), 64'd3);

    // Release from full, then the next row wraps to slot 0.
    pulse_release();
    check_state("rel1", 2'd2, 2'd1);
    check("rel1_ready", {63'd0, s_axis_if.ready}, 64'd1);
    send_row(3, 3'b001, 4, 1'b0);
    @(negedge clk);
    check_state("row3", 2'd3, 2'd1);

    // Down to one row, then completion and release in the same cycle.
    pulse_release();
    pulse_release();
    check_state("rel3", 2'd1, 2'd0);
    send_row(4, 3'b010, 4, 1'b1);
    @(negedge clk);
    check_state("coincide", 2'd1, 2'd1);
    check("coincide_done_cnt", 64'(done_cnt), 64'd5);

    // Six beats into a four-word row: beats 4 and 5 are dropped.
    send_row(5, 3'b100, 6, 1'b0);
    @(negedge clk);
    check("ovf_flag", {63'd0, wr_overflow}, 64'd1);
    check_state("ovf", 2'd2, 2'd1);
    check("ovf_done_cnt", 64'(done_cnt), 64'd6);

    // Flush after a partial row with two rows held.
    pulse_release();
    check_state("rel4", 2'd1, 2'd2);
    send_row(6, 3'b001, 4, 1'b0);
    send_beat({16'hC0DE, 16'd7, 16'd0, 16'd0}, 4'b0000, 1'b0, 1'b1, 3'b010, 16'd0, 1'b0);
    send_beat({16'hC0DE, 16'd7, 16'd0, 16'd1}, 4'b0000, 1'b0, 1'b1, 3'b010, 16'd1, 1'b0);
    @(negedge clk);
    check_state("pre_clr", 2'd2, 2'd2);
    fmap_clr = 1'b1;
    s_axis_if.data  = 64'hDEAD_BEEF_0000_0002;
    s_axis_if.valid = 1'b1;
    #1;
    check("clr_ready", {63'd0, s_axis_if.ready}, 64'd0);
    idle();
    check_state("clr", 2'd0, 2'd0);
    check("clr_overflow", {63'd0, wr_overflow}, 64'd0);
    send_row(8, 3'b001, 4, 1'b0);
    @(negedge clk);
    check_state("row8", 2'd1, 2'd0);

    // Reset while a row is in flight and valid is high.
    send_beat({16'hC0DE, 16'd9, 16'd0, 16'd0}, 4'b0000, 1'b0, 1'b1, 3'b010, 16'd0, 1'b0);
    send_beat({16'hC0DE, 16'd9, 16'd0, 16'd1}, 4'b0000, 1'b0, 1'b0, 3'b010, 16'd1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_wen",   {61'd0, buffer_wen}, 64'd0);
    check("mid_rst_waddr", {48'd0, buffer_waddr}, 64'd0);
    check("mid_rst_din",   buffer_din, 64'd0);
    check_state("mid_rst", 2'd0, 2'd0);
    check("mid_rst_ready", {63'd0, s_axis_if.ready}, 64'd0);
    repeat (2) @(negedge clk);
    s_axis_if.valid = 1'b0;
    rst_n = 1'b1;
    send_row(10, 3'b001, 4, 1'b0);
    @(negedge clk);
    check_state("row10", 2'd1, 2'd0);
    check("final_done_cnt", 64'(done_cnt), 64'd9);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
